instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the encoded-word queue depth (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the producer presents an operation.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept an operation this cycle.
REQ-006 The block SHALL have ports I (input, 1, immediate form), S (input, 3, ALU select) and Cin (input, 1, carry-in).
REQ-007 The block SHALL have ports rs, rt and rd (each input, 5, register specifiers) and imm (input, 16, immediate value).
REQ-008 The block SHALL have port ibus, output, 32, the encoded instruction word at the queue head.
REQ-009 The block SHALL have port out_valid, output, 1, meaning ibus holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes ibus this cycle.
REQ-011 The block SHALL have port err, output, 1, a one-cycle pulse flagging a rejected illegal operation.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1, the current queue occupancy.

Function
REQ-013 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; a pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (count != DEPTH), combinationally from registered state only; it SHALL NOT depend on out_ready.
REQ-015 Legal (S,Cin) pairs SHALL be: 010/0 add, 011/1 sub, 000/0 xor, 110/0 or, 100/0 and; every other pair SHALL be illegal.
REQ-016 For I=1, the word SHALL be opcode[31:26] = 000011 add, 000010 sub, 000001 xor, 001111 or, 001100 and; rs[25:21]; rt[20:16]; imm[15:0].
REQ-017 For I=0, the word SHALL be [31:26]=000000; rs[25:21]; rt[20:16]; rd[15:11]; [10:6]=00000; funct[5:0] = 000011 add, 000010 sub, 000001 xor, 000111 or, 000100 and.
REQ-018 For I=0, imm SHALL be ignored; for I=1, rd SHALL be ignored.
REQ-019 An accepted legal operation SHALL be enqueued; an accepted illegal operation SHALL NOT be enqueued, and err SHALL be 1 for exactly the following cycle.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N into an empty queue SHALL appear on ibus with out_valid=1 after edge N.
REQ-021 The queue SHALL be FIFO-ordered, with read/write pointers wrapping modulo DEPTH.
REQ-022 out_valid SHALL equal (count != 0); ibus SHALL be 32'h00000000 whenever out_valid=0.
REQ-023 ibus and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 On a simultaneous legal accept and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 On a simultaneous illegal accept and pop, count SHALL decrement by 1.
REQ-026 When full, an in_valid operation SHALL NOT be accepted, and err SHALL NOT pulse for it, even if a pop occurs in the same cycle.
REQ-027 out_ready with count=0 SHALL have no effect; count SHALL never underflow or exceed DEPTH.

Reset
REQ-028 While reset_n=0, asynchronously: count=0, pointers=0, out_valid=0, ibus=0, err=0, in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all queued words; the first accept after release SHALL behave as into an empty queue.
REQ-030 Queue storage contents SHALL NOT be required to reset; only pointers and the count are reset.

Verification
REQ-031 The bench SHALL check: I=1,S=010,Cin=0,rs=1,rt=2,imm=16'h0005 -> next cycle ibus=32'h0C220005, out_valid=1, count=1.
REQ-032 The bench SHALL check: I=0,S=110,Cin=0,rs=3,rt=4,rd=5 -> ibus=32'h00642807; I=0,S=011,Cin=1, same regs -> ibus=32'h00642802.
REQ-033 The bench SHALL check: S=111, or S=011 with Cin=0, or S=010 with Cin=1 -> err pulses 1 cycle, count unchanged, out_valid unchanged.
REQ-034 The bench SHALL check: with out_ready=0, push DEPTH legal ops -> in_ready=0, count=DEPTH; extra in_valid is ignored; then drain returns words in order with wrap.
REQ-035 The bench SHALL check: when full, simultaneous in_valid and out_ready -> pop only, count=DEPTH-1; with count=2, push and pop together -> count stays 2.
REQ-036 The bench SHALL check: reset_n low with count=3 -> immediately out_valid=0, ibus=0, count=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder with an output word queue.
// Each accepted (I, S, Cin, rs, rt, rd, imm) operation is checked for a legal ALU
// select/carry pair. Legal operations are encoded into a 32-bit I-type or R-type
// word and pushed into a FIFO of DEPTH entries. Illegal operations are dropped,
// and err pulses for one cycle. ibus always shows the FIFO head, or zero when the
// FIFO is empty.
module instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     I,
  input  logic [2:0]               S,
  input  logic                     Cin,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [15:0]              imm,
  output logic [31:0]              ibus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic        legal;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] word;
  logic        accept;
  logic        push;
  logic        pop;

  // Decode the ALU select and carry-in pair into I-type opcode and R-type funct
  always_comb begin
    legal  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b000000;
    case ({S, Cin})
      4'b0100: begin legal = 1'b1; opcode = 6'b000011; funct = 6'b000011; end // add
      4'b0111: begin legal = 1'b1; opcode = 6'b000010; funct = 6'b000010; end // sub
      4'b0000: begin legal = 1'b1; opcode = 6'b000001; funct = 6'b000001; end // xor
      4'b1100: begin legal = 1'b1; opcode = 6'b001111; funct = 6'b000111; end // or
      4'b1000: begin legal = 1'b1; opcode = 6'b001100; funct = 6'b000100; end // and
      default: begin legal = 1'b0; opcode = 6'b000000; funct = 6'b000000; end
    endcase
  end

  // Assemble the instruction word: the immediate form ignores rd, the register form ignores imm
  always_comb begin
    if (I) begin
      word = {opcode, rs, rt, imm};
    end else begin
      word = {6'b000000, rs, rt, rd, 5'b00000, funct};
    end
  end

  // Handshake qualifiers and the combinational outputs derived from registered state
  always_comb begin
    in_ready  = (count_q != CntW'(DEPTH));
    out_valid = (count_q != '0);
    accept    = in_valid && in_ready;
    push      = accept && legal;
    pop       = out_valid && out_ready;
    ibus      = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
    err       = err_q;
    count     = count_q;
  end

  // Next-state for pointers, occupancy and the error pulse
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept && !legal;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Queue storage is not reset; only words below the occupancy count are ever visible
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        I;
  logic [2:0]  S;
  logic        Cin;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] ibus;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [2:0]  count;

  int checks;
  int failures;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I         (I),
    .S         (S),
    .Cin       (Cin),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .ibus      (ibus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic i_f, input logic [2:0] s_f, input logic c_f,
                        input logic [4:0] rs_f, input logic [4:0] rt_f,
                        input logic [4:0] rd_f, input logic [15:0] imm_f);
    I   = i_f;
    S   = s_f;
    Cin = c_f;
    rs  = rs_f;
    rt  = rt_f;
    rd  = rd_f;
    imm = imm_f;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0000);
    #12;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ibus", ibus, 32'h0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // add immediate
    set_op(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd31, 16'h0005);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("addi_ibus", ibus, 32'h0C22_0005);
    check_eq("addi_out_valid", 32'(out_valid), 32'd1);
    check_eq("addi_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("addi_pop_count", 32'(count), 32'd0);
    check_eq("empty_ibus", ibus, 32'h0);

    // register-form or, then sub; imm must be ignored
    set_op(1'b0, 3'b110, 1'b0, 5'd3, 5'd4, 5'd5, 16'hFFFF);
    in_valid = 1'b1;
    step();
    check_eq("or_ibus", ibus, 32'h0064_2807);
    set_op(1'b0, 3'b011, 1'b1, 5'd3, 5'd4, 5'd5, 16'h1234);
    step();
    in_valid = 1'b0;
    check_eq("two_count", 32'(count), 32'd2);
    check_eq("head_stable", ibus, 32'h0064_2807);
    step();
    check_eq("head_hold", ibus, 32'h0064_2807);
    out_ready = 1'b1;
    step();
    check_eq("sub_ibus", ibus, 32'h0064_2802);
    step();
    out_ready = 1'b0;
    check_eq("drain_count", 32'(count), 32'd0);

    // illegal on empty queue
    set_op(1'b1, 3'b111, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("ill111_err", 32'(err), 32'd1);
    check_eq("ill111_count", 32'(count), 32'd0);
    check_eq("ill111_out_valid", 32'(out_valid), 32'd0);
    step();
    check_eq("ill111_err_clear", 32'(err), 32'd0);

    // one legal xor queued, then illegal sub-without-carry and add-with-carry
    set_op(1'b1, 3'b000, 1'b0, 5'd7, 5'd8, 5'd0, 16'hABCD);
    in_valid = 1'b1;
    step();
    check_eq("xori_ibus", ibus, 32'h04E8_ABCD);
    set_op(1'b1, 3'b011, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0001);
    step();
    check_eq("ill011_err", 32'(err), 32'd1);
    check_eq("ill011_count", 32'(count), 32'd1);
    check_eq("ill011_out_valid", 32'(out_valid), 32'd1);
    set_op(1'b0, 3'b010, 1'b1, 5'd1, 5'd1, 5'd1, 16'h0001);
    step();
    check_eq("ill010c_err", 32'(err), 32'd1);
    check_eq("ill010c_count", 32'(count), 32'd1);
    check_eq("ill010c_ibus", ibus, 32'h04E8_ABCD);
    // illegal accept alongside a pop
    set_op(1'b0, 3'b101, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0001);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("illpop_err", 32'(err), 32'd1);
    check_eq("illpop_count", 32'(count), 32'd0);
    step();
    check_eq("illpop_err_clear", 32'(err), 32'd0);

    // offset the pointers by one so the fill wraps mid-queue
    set_op(1'b1, 3'b100, 1'b0, 5'd0, 5'd0, 5'd0, 16'h00FF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("andi_ibus", ibus, 32'h3000_00FF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // fill with addi rs=1 rt=2 imm=0x10+k
    for (int k = 0; k < DEPTH; k++) begin
      set_op(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 16'(16'h0010 + k));
      in_valid = 1'b1;
      step();
    end
    check_eq("full_count", 32'(count), 32'(DEPTH));
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    // extra illegal op while full: neither accepted nor flagged
    set_op(1'b1, 3'b111, 1'b1, 5'd1, 5'd2, 5'd0, 16'h0099);
    step();
    check_eq("full_extra_count", 32'(count), 32'(DEPTH));
    check_eq("full_extra_err", 32'(err), 32'd0);
    check_eq("full_head", ibus, 32'h0C22_0010);
    // full with push and pop together: pop only
    set_op(1'b1, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 16'h0077);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("full_pop_count", 32'(count), 32'(DEPTH - 1));
    check_eq("full_pop_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      check_eq($sformatf("drain_%0d", k), ibus, 32'h0C22_0010 + 32'(k));
      step();
    end
    out_ready = 1'b0;
    check_eq("drained_out_valid", 32'(out_valid), 32'd0);
    // pop on an empty queue has no effect
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("empty_pop_count", 32'(count), 32'd0);

    // count=2 with push and pop together
    set_op(1'b0, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0000);
    in_valid = 1'b1;
    step();
    set_op(1'b0, 3'b000, 1'b0, 5'd2, 5'd2, 5'd2, 16'h0000);
    step();
    set_op(1'b0, 3'b000, 1'b0, 5'd3, 5'd3, 5'd3, 16'h0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("pushpop_count", 32'(count), 32'd2);
    check_eq("pushpop_head", ibus, 32'h0042_1001);
    step();
    in_valid = 1'b0;
    check_eq("three_count", 32'(count), 32'd3);

    // asynchronous reset mid-operation
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_ibus", ibus, 32'h0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    set_op(1'b1, 3'b110, 1'b0, 5'd9, 5'd10, 5'd0, 16'h00F0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("post_rst_count", 32'(count), 32'd1);
    check_eq("post_rst_ibus", ibus, 32'h3D2A_00F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
